// File: rtl/game_turn_fsm.sv
// Turn sequencer for a two-player drop-piece game: accepts column drops,
// tracks column heights and move count, and resolves each placement from an external win checker.
//
// state    | meaning
// ---------+-----------------------------------------------
// GAME_INIT| idle, waiting for start
// P1_TURN  | player 1 may drop (or a P1 check is pending)
// P2_TURN  | player 2 may drop (or a P2 check is pending)
// END_GAME | game over, game_status holds result
module game_turn_fsm #(
  parameter int N_COLS = 7,
  parameter int N_ROWS = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       drop_req,
  input  logic [2:0] drop_col,
  input  logic       chk_done,
  input  logic       chk_win,
  output logic [1:0] state,
  output logic [1:0] game_status,
  output logic       place_valid,
  output logic [2:0] place_col,
  output logic [2:0] place_row,
  output logic       place_player,
  output logic       drop_err,
  output logic       busy,
  output logic [5:0] move_count
);

  localparam int HW = $clog2(N_ROWS + 1);

  localparam logic [1:0] S_INIT = 2'b00;
  localparam logic [1:0] S_P1   = 2'b01;
  localparam logic [1:0] S_P2   = 2'b10;
  localparam logic [1:0] S_END  = 2'b11;

  localparam logic [1:0] GS_PLAY = 2'b00;
  localparam logic [1:0] GS_P1W  = 2'b01;
  localparam logic [1:0] GS_P2W  = 2'b10;
  localparam logic [1:0] GS_TIE  = 2'b11;

  logic [1:0]    state_q, state_d;
  logic [1:0]    status_q, status_d;
  logic          pv_q, pv_d;
  logic [2:0]    pcol_q, pcol_d;
  logic [2:0]    prow_q, prow_d;
  logic          ppl_q, ppl_d;
  logic          err_q, err_d;
  logic          busy_q, busy_d;
  logic [5:0]    mc_q, mc_d;
  logic [HW-1:0] height_q [N_COLS];
  logic [HW-1:0] height_d [N_COLS];

  logic [HW-1:0] sel_h;
  logic          drop_ok;

  // Column select done by loop so an out-of-range drop_col never indexes past the array.
  always_comb begin
    sel_h = '0;
    for (int c = 0; c < N_COLS; c++) begin
      if (drop_col == 3'(c)) sel_h = height_q[c];
    end
    drop_ok = (int'(drop_col) < N_COLS) && (int'(sel_h) < N_ROWS);
  end

  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    pv_d     = 1'b0;
    err_d    = 1'b0;
    pcol_d   = pcol_q;
    prow_d   = prow_q;
    ppl_d    = ppl_q;
    busy_d   = busy_q;
    mc_d     = mc_q;
    for (int c = 0; c < N_COLS; c++) height_d[c] = height_q[c];

    case (state_q)
      S_INIT: begin
        if (start) state_d = S_P1;
      end
      S_P1, S_P2: begin
        if (busy_q) begin
          if (chk_done) begin
            busy_d = 1'b0;
            if (chk_win) begin
              state_d  = S_END;
              status_d = ppl_q ? GS_P2W : GS_P1W;
            end else if (mc_q == 6'(N_COLS * N_ROWS)) begin
              state_d  = S_END;
              status_d = GS_TIE;
            end else begin
              state_d = (state_q == S_P1) ? S_P2 : S_P1;
            end
          end
        end else if (drop_req) begin
          if (drop_ok) begin
            pv_d   = 1'b1;
            pcol_d = drop_col;
            prow_d = 3'(sel_h);
            ppl_d  = (state_q == S_P2);
            busy_d = 1'b1;
            mc_d   = mc_q + 6'd1;
            for (int c = 0; c < N_COLS; c++) begin
              if (drop_col == 3'(c)) height_d[c] = height_q[c] + HW'(1);
            end
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: begin
        if (start) begin
          state_d  = S_INIT;
          status_d = GS_PLAY;
          mc_d     = '0;
          for (int c = 0; c < N_COLS; c++) height_d[c] = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_INIT;
      status_q <= GS_PLAY;
      pv_q     <= 1'b0;
      pcol_q   <= '0;
      prow_q   <= '0;
      ppl_q    <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      mc_q     <= '0;
      for (int c = 0; c < N_COLS; c++) height_q[c] <= '0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      pv_q     <= pv_d;
      pcol_q   <= pcol_d;
      prow_q   <= prow_d;
      ppl_q    <= ppl_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      mc_q     <= mc_d;
      for (int c = 0; c < N_COLS; c++) height_q[c] <= height_d[c];
    end
  end

  assign state        = state_q;
  assign game_status  = status_q;
  assign place_valid  = pv_q;
  assign place_col    = pcol_q;
  assign place_row    = prow_q;
  assign place_player = ppl_q;
  assign drop_err     = err_q;
  assign busy         = busy_q;
  assign move_count   = mc_q;

endmodule

// File: tb/tb_game_turn_fsm.sv
// Bench for game_turn_fsm: directed scenarios plus random play, every cycle
// compared against a board-level reference model.
module tb_game_turn_fsm;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0, drop_req = 1'b0, chk_done = 1'b0, chk_win = 1'b0;
  logic [2:0] drop_col = 3'd0;
  logic [1:0] state, game_status;
  logic       place_valid, place_player, drop_err, busy;
  logic [2:0] place_col, place_row;
  logic [5:0] move_count;

  game_turn_fsm dut (
    .clk(clk), .rst_n(rst_n), .start(start), .drop_req(drop_req),
    .drop_col(drop_col), .chk_done(chk_done), .chk_win(chk_win),
    .state(state), .game_status(game_status), .place_valid(place_valid),
    .place_col(place_col), .place_row(place_row), .place_player(place_player),
    .drop_err(drop_err), .busy(busy), .move_count(move_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: board as plain integer heights, phase as a small enum.
  int m_phase;  // 0 idle, 1 p1, 2 p2, 3 over
  int m_result; // 0 playing, 1 p1 won, 2 p2 won, 3 tie
  int m_h [8];
  int m_moves, m_col, m_row, m_who;
  bit m_pending, m_pv, m_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string p);
    check({p, ".state"},  32'(state),        32'(m_phase));
    check({p, ".status"}, 32'(game_status),  32'(m_result));
    check({p, ".pv"},     32'(place_valid),  32'(m_pv));
    check({p, ".col"},    32'(place_col),    32'(m_col));
    check({p, ".row"},    32'(place_row),    32'(m_row));
    check({p, ".who"},    32'(place_player), 32'(m_who));
    check({p, ".err"},    32'(drop_err),     32'(m_err));
    check({p, ".busy"},   32'(busy),         32'(m_pending));
    check({p, ".moves"},  32'(move_count),   32'(m_moves));
  endtask

  task automatic model_reset();
    m_phase = 0; m_result = 0; m_moves = 0; m_col = 0; m_row = 0; m_who = 0;
    m_pending = 0; m_pv = 0; m_err = 0;
    foreach (m_h[i]) m_h[i] = 0;
  endtask

  task automatic model_step(input bit s, input bit dr, input int c, input bit cd, input bit cw);
    m_pv = 0; m_err = 0;
    if (m_phase == 0) begin
      if (s) m_phase = 1;
    end else if (m_phase == 3) begin
      if (s) begin
        m_phase = 0; m_result = 0; m_moves = 0;
        foreach (m_h[i]) m_h[i] = 0;
      end
    end else if (m_pending) begin
      if (cd) begin
        m_pending = 0;
        if (cw) begin m_phase = 3; m_result = m_who + 1; end
        else if (m_moves == 42) begin m_phase = 3; m_result = 3; end
        else m_phase = 3 - m_phase;
      end
    end else if (dr) begin
      if (c < 7 && m_h[c] < 6) begin
        m_pv = 1; m_col = c; m_row = m_h[c]; m_who = m_phase - 1;
        m_h[c]++; m_moves++; m_pending = 1;
      end else begin
        m_err = 1;
      end
    end
  endtask

  task automatic cyc(input string p, input bit s, input bit dr, input int c, input bit cd, input bit cw);
    @(negedge clk);
    start = s; drop_req = dr; drop_col = 3'(c); chk_done = cd; chk_win = cw;
    model_step(s, dr, c, cd, cw);
    @(posedge clk);
    #1;
    check_all(p);
    start = 0; drop_req = 0; chk_done = 0; chk_win = 0;
  endtask

  task automatic do_reset(input string p);
    @(negedge clk);
    start = 0; drop_req = 0; chk_done = 0; chk_win = 0; drop_col = 0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all({p, ".async"});
    @(negedge clk);
    #1 check_all({p, ".hold"});
    rst_n = 1'b1;
  endtask

  // 42 drops filling columns left to right, each resolved without a win
  // except optionally the last one.
  task automatic fill_board(input string p, input bit win_last);
    for (int col = 0; col < 7; col++) begin
      for (int r = 0; r < 6; r++) begin
        cyc(p, 0, 1, col, 0, 0);
        cyc(p, 0, 0, 0, 1, win_last && col == 6 && r == 5);
      end
    end
  endtask

  initial begin
    model_reset();
    do_reset("por");

    cyc("init_drop", 0, 1, 3, 0, 0);
    cyc("start", 1, 0, 0, 0, 0);
    cyc("drop3", 0, 1, 3, 0, 0);
    check("s1.state", 32'(state), 32'd1);
    check("s1.col", 32'(place_col), 32'd3);
    check("s1.row", 32'(place_row), 32'd0);
    check("s1.mc", 32'(move_count), 32'd1);
    cyc("busy_drop", 0, 1, 4, 0, 0);
    cyc("chk1", 0, 0, 0, 1, 0);
    check("s2.state", 32'(state), 32'd2);
    cyc("drop3b", 0, 1, 3, 0, 0);
    check("s2.row", 32'(place_row), 32'd1);
    check("s2.who", 32'(place_player), 32'd1);
    cyc("chk2", 0, 0, 0, 1, 0);
    cyc("stray_chk", 0, 0, 0, 1, 1);
    cyc("turn_start", 1, 0, 0, 0, 0);

    for (int i = 0; i < 6; i++) begin
      cyc("fill0", 0, 1, 0, 0, 0);
      cyc("fill0_chk", 0, 0, 0, 1, 0);
    end
    cyc("col0_full", 0, 1, 0, 0, 0);
    check("s3.err_full", 32'(drop_err), 32'd1);
    check("s3.mc", 32'(move_count), 32'd8);
    cyc("col7", 0, 1, 7, 0, 0);
    check("s3.err_col7", 32'(drop_err), 32'd1);

    cyc("p1_drop", 0, 1, 1, 0, 0);
    cyc("p1_chk", 0, 0, 0, 1, 0);
    cyc("p2_drop", 0, 1, 1, 0, 0);
    cyc("p2_win", 0, 0, 0, 1, 1);
    check("s4.state", 32'(state), 32'd3);
    check("s4.status", 32'(game_status), 32'd2);
    cyc("end_drop", 0, 1, 2, 0, 0);
    cyc("end_start", 1, 0, 0, 0, 0);
    cyc("restart", 1, 0, 0, 0, 0);

    for (int i = 0; i < 1500; i++) begin
      bit s, dr, cd, cw;
      int c;
      s  = ($urandom % 20) == 0;
      dr = ($urandom % 2) == 0;
      c  = $urandom_range(0, 7);
      cd = m_pending ? (($urandom % 3) == 0) : (($urandom % 5) == 0);
      cw = ($urandom % 15) == 0;
      cyc("rand", s, dr, c, cd, cw);
    end

    do_reset("tie_rst");
    cyc("tie_start", 1, 0, 0, 0, 0);
    fill_board("tie", 0);
    check("s5.tie_state", 32'(state), 32'd3);
    check("s5.tie_status", 32'(game_status), 32'd3);
    cyc("tie_clr", 1, 0, 0, 0, 0);
    check("s5.clr_mc", 32'(move_count), 32'd0);
    cyc("win42_start", 1, 0, 0, 0, 0);
    fill_board("win42", 1);
    check("s5.win42_status", 32'(game_status), 32'd2);

    do_reset("busy_rst0");
    cyc("b_start", 1, 0, 0, 0, 0);
    cyc("b_drop", 0, 1, 5, 0, 0);
    check("s6.busy", 32'(busy), 32'd1);
    do_reset("busy_rst");
    cyc("b_chk", 0, 0, 0, 1, 1);
    cyc("b_drop2", 0, 1, 2, 0, 0);
    check("s6.state", 32'(state), 32'd0);
    cyc("b_start2", 1, 0, 0, 0, 0);
    check("s6.p1", 32'(state), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
